// File: rtl/bird_motion_ctrl_if.sv
// Motion link between the flap controller (master) and the bird column (slave).
// Carries the board/game inputs the controller consumes and the per-tick move pulses it emits.
interface bird_motion_ctrl_if;
  logic btn;
  logic pause;
  logic game_over;
  logic key;
  logic gravity;
  logic tick;

  modport master (
    input  btn,
    input  pause,
    input  game_over,
    output key,
    output gravity,
    output tick
  );

  modport slave (
    output btn,
    output pause,
    output game_over,
    input  key,
    input  gravity,
    input  tick
  );
endinterface

// File: rtl/bird_motion_ctrl.sv
// Bird motion sequencer: synchronizes the flap button, divides clk into game ticks and
// emits at most one registered up (key) or down (gravity) pulse per tick.
module bird_motion_ctrl #(
  parameter int unsigned TICK_DIV  = 8,
  parameter int unsigned FLAP_ROWS = 2
) (
  input  logic              clk,
  input  logic              reset,
  bird_motion_ctrl_if.master bus
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam int unsigned RW = $clog2(FLAP_ROWS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [RW-1:0] RISE_INIT = RW'(FLAP_ROWS - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_RISE,
    S_FALL,
    S_DEAD
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rise_rem_q, rise_rem_d;
  logic          flap_pending_q, flap_pending_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          sync3_q, sync3_d;
  logic          key_q, key_d;
  logic          gravity_q, gravity_d;
  logic          tick_q, tick_d;
  logic          press;
  logic          tick_ev;

  // Next-state and pulse generation; synchronizer always tracks btn so a held
  // button across pause or death never looks like a fresh edge.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rise_rem_d     = rise_rem_q;
    flap_pending_d = flap_pending_q;
    sync1_d        = bus.btn;
    sync2_d        = sync1_q;
    sync3_d        = sync2_q;
    key_d          = 1'b0;
    gravity_d      = 1'b0;
    tick_d         = 1'b0;
    press          = sync2_q & ~sync3_q;
    tick_ev        = 1'b0;

    if (bus.game_over) begin
      state_d        = S_DEAD;
      flap_pending_d = 1'b0;
      cnt_d          = '0;
    end else if (state_q == S_DEAD) begin
      cnt_d = '0;
    end else if (!bus.pause) begin
      tick_ev = (cnt_q == CNT_LAST);
      cnt_d   = tick_ev ? '0 : cnt_q + CW'(1);
      if (tick_ev) begin
        tick_d = 1'b1;
        if (flap_pending_q || press) begin
          key_d          = 1'b1;
          rise_rem_d     = RISE_INIT;
          flap_pending_d = 1'b0;
          state_d        = (FLAP_ROWS > 1) ? S_RISE : S_FALL;
        end else begin
          case (state_q)
            S_RISE: begin
              key_d      = 1'b1;
              rise_rem_d = rise_rem_q - RW'(1);
              if (rise_rem_q == RW'(1)) state_d = S_FALL;
            end
            S_FALL:  gravity_d = 1'b1;
            default: ;
          endcase
        end
      end else if (press) begin
        flap_pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_WAIT;
      cnt_q          <= '0;
      rise_rem_q     <= '0;
      flap_pending_q <= 1'b0;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      sync3_q        <= 1'b0;
      key_q          <= 1'b0;
      gravity_q      <= 1'b0;
      tick_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rise_rem_q     <= rise_rem_d;
      flap_pending_q <= flap_pending_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      sync3_q        <= sync3_d;
      key_q          <= key_d;
      gravity_q      <= gravity_d;
      tick_q         <= tick_d;
    end
  end

  assign bus.key     = key_q;
  assign bus.gravity = gravity_q;
  assign bus.tick    = tick_q;

endmodule

// File: doc/bird_motion_ctrl.md
Name: bird_motion_ctrl

Overview:
Generates the per-tick `key` (move up) and `gravity` (move down) pulses that drive the bird column's light cells. It is the transmitting end of that interface.
- Input side: takes the raw flap button, synchronizes and edge-detects it, and divides the system clock into game ticks.
- Output side: sequences flap and fall motion so each tick produces at most one up or one down move.
- Sits between the board button/clock and the bird column; it also consumes the global `pause` and `game_over` signals.

Parameters:
TICK_DIV, 8, clock cycles per game tick (≥2; top level overrides it for real hardware rates).
FLAP_ROWS, 2, number of up-moves produced per flap (≥1).

Ports:
clk  input  1  system clock; all logic is on posedge clk.
reset  input  1  synchronous, active-high reset.
pause  input  1  freezes all motion state while high.
game_over  input  1  collision/end flag; when high, stops motion until reset.
btn  input  1  raw flap button, active-high (already inverted from the board KEY), asynchronous.
key  output  1  one-cycle pulse: bird moves up one row.
gravity  output  1  one-cycle pulse: bird moves down one row.
tick  output  1  one-cycle game-tick strobe (debug and pipe-scroll use).

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset values:
  - state = WAIT, tick counter = 0, rise_rem = 0, flap_pending = 0.
  - Synchronizer FFs = 0.
  - key = gravity = tick = 0.
- Button path:
  - 2-FF synchronizer, then a third FF for edge detection; press = sync2 & ~sync3.
  - A held button produces exactly one press.
  - A press sets flap_pending; a second press before service is absorbed (no double flap).
- Tick counter:
  - Counts 0..TICK_DIV-1 in WAIT/RISE/FALL when pause = 0.
  - The internal tick event occurs when count == TICK_DIV-1; the counter then wraps to 0.
- Output registration: tick, key and gravity are registered, and each goes high for exactly one cycle, in the cycle after the tick event.
- Mutual exclusion: key and gravity are never both 1.
- States:
  - WAIT: bird hovers and no pulses are emitted. Exits only via a serviced press.
  - RISE: on each tick, key = 1 and rise_rem decrements; when rise_rem == 1 at the tick, next state is FALL.
  - FALL: on each tick, gravity = 1.
  - DEAD: the counter is held at 0, tick/key/gravity stay 0, and presses are ignored. Exit only via reset.
- Flap service: on a tick event, if flap_pending = 1 or a press occurs in that same cycle:
  - key = 1, rise_rem = FLAP_ROWS-1, and flap_pending is cleared.
  - Next state is RISE if FLAP_ROWS > 1, otherwise FALL.
  - Applies from WAIT, RISE (restarts the rise count) or FALL.
- Pause:
  - Counter, state, rise_rem and flap_pending are all held; key = gravity = tick = 0.
  - Presses during pause are discarded, but the synchronizer keeps tracking, so a button held across unpause does not fire.
  - On unpause, counting resumes from the held value.
- Priority: reset > game_over > pause > normal operation.
  - game_over = 1 forces DEAD on the next edge, clears pending, and zeroes outputs the same edge.
- Reset mid-RISE/FALL/DEAD returns to the full reset state on the next edge; no pulse is emitted in that cycle.
- Counter width is $clog2(TICK_DIV) bits; rise_rem width is $clog2(FLAP_ROWS+1) bits.

Test Plan:
All scenarios use TICK_DIV=4, FLAP_ROWS=2.
1. Idle: reset 2 cycles, btn = 0 for 20 cycles -> tick pulses every 4 cycles; key = gravity = 0 throughout (WAIT).
2. Flap then fall: hold btn = 1 from cycle 5 onward -> key high on the first 2 ticks after the synchronized edge, then gravity on every subsequent tick (4-cycle spacing). No second flap while held; key and gravity are never both high.
3. Re-flap: press during RISE after the 1st key pulse -> total of 3 consecutive key ticks, then gravity resumes. Two presses inside one tick window -> only 2 key ticks.
4. Pause: in FALL, assert pause 10 cycles mid-count (count = 2) -> no tick/gravity during pause. After release the next gravity arrives 2 cycles later (count resumes from 2). A press during pause produces no flap.
5. Game over: in FALL, assert game_over 1 cycle -> key/gravity/tick stay 0 for 30+ cycles despite btn presses. reset -> WAIT, counter 0.
6. Reset mid-RISE: assert reset between the two key pulses -> no further key pulse; outputs 0 and state WAIT after the edge.
